// File: rtl/register_file.sv
// register_file: 16-entry x 16-bit general-purpose register file.
//   Five combinational read ports (ALU operands 1/2, offset, store data,
//   branch target) and one synchronous write port whose data is muxed
//   between the memory data register and the ALU result.
// Ports:
//   D_ReadReg1RT, D_ReadReg2RT, D_Offset, D_RegSW, D_BT : read data out
//   D_MDR_IN, D_ALU_IN                                  : write data candidates
//   A_ReadReg1RT, A_ReadReg2RT, A_Offset                : read addresses
//   A_RegSWLW        : SW read address / LW write destination
//   A_WriteRegRT_BT  : R-type write destination / BT read address
//   C_RegDstWrite    : 1 = write A_WriteRegRT_BT, 0 = write A_RegSWLW
//   C_RegWrite       : write enable
//   C_MemToReg       : 1 = write D_MDR_IN, 0 = write D_ALU_IN
//   clk, rst         : clock, asynchronous active-low reset
// Option: define REG_ZERO_HARDWIRED_EN to make R0 read as zero and drop
//   writes addressed to it.
module register_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 16
) (
  output logic [DATA_W-1:0] D_ReadReg1RT,
  output logic [DATA_W-1:0] D_ReadReg2RT,
  output logic [DATA_W-1:0] D_Offset,
  output logic [DATA_W-1:0] D_RegSW,
  output logic [DATA_W-1:0] D_BT,
  input  logic [DATA_W-1:0] D_MDR_IN,
  input  logic [DATA_W-1:0] D_ALU_IN,
  input  logic [ADDR_W-1:0] A_ReadReg1RT,
  input  logic [ADDR_W-1:0] A_ReadReg2RT,
  input  logic [ADDR_W-1:0] A_Offset,
  input  logic [ADDR_W-1:0] A_RegSWLW,
  input  logic [ADDR_W-1:0] A_WriteRegRT_BT,
  input  logic              C_RegDstWrite,
  input  logic              C_RegWrite,
  input  logic              C_MemToReg,
  input  logic              clk,
  input  logic              rst
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              wr_en_c;

  // Write destination / data selection and enable qualification.
  always_comb begin
    wr_addr_c = C_RegDstWrite ? A_WriteRegRT_BT : A_RegSWLW;
    wr_data_c = C_MemToReg ? D_MDR_IN : D_ALU_IN;
`ifdef REG_ZERO_HARDWIRED_EN
    // R0 never leaves its reset value, so it reads zero without read-side gating.
    wr_en_c   = C_RegWrite && (wr_addr_c != ADDR_W'(0));
`else
    wr_en_c   = C_RegWrite;
`endif
  end

  // Register array; reset clears every entry and overrides a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[wr_addr_c] <= wr_data_c;
    end
  end

  // Zero-latency reads with no write bypass: old value until the edge.
  assign D_ReadReg1RT = regs_q[A_ReadReg1RT];
  assign D_ReadReg2RT = regs_q[A_ReadReg2RT];
  assign D_Offset     = regs_q[A_Offset];
  assign D_RegSW      = regs_q[A_RegSWLW];
  assign D_BT         = regs_q[A_WriteRegRT_BT];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic [15:0] D_ReadReg1RT, D_ReadReg2RT, D_Offset, D_RegSW, D_BT;
  logic [15:0] D_MDR_IN, D_ALU_IN;
  logic [3:0]  A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT;
  logic        C_RegDstWrite, C_RegWrite, C_MemToReg;
  logic        clk, rst;

  int tests;
  int fails;
  bit cmp_en;

  // Reference contents: what each architectural register must hold.
  logic [15:0] model [16];

  register_file dut (
    .D_ReadReg1RT    (D_ReadReg1RT),
    .D_ReadReg2RT    (D_ReadReg2RT),
    .D_Offset        (D_Offset),
    .D_RegSW         (D_RegSW),
    .D_BT            (D_BT),
    .D_MDR_IN        (D_MDR_IN),
    .D_ALU_IN        (D_ALU_IN),
    .A_ReadReg1RT    (A_ReadReg1RT),
    .A_ReadReg2RT    (A_ReadReg2RT),
    .A_Offset        (A_Offset),
    .A_RegSWLW       (A_RegSWLW),
    .A_WriteRegRT_BT (A_WriteRegRT_BT),
    .C_RegDstWrite   (C_RegDstWrite),
    .C_RegWrite      (C_RegWrite),
    .C_MemToReg      (C_MemToReg),
    .clk             (clk),
    .rst             (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset wipes everything at once; a write lands on the rising edge.
  always @(rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end
  end

  always @(posedge clk) begin
    logic [3:0] dst;
    dst = C_RegDstWrite ? A_WriteRegRT_BT : A_RegSWLW;
    if (rst === 1'b1 && C_RegWrite === 1'b1) begin
`ifdef REG_ZERO_HARDWIRED_EN
      if (dst != 4'd0) model[dst] = C_MemToReg ? D_MDR_IN : D_ALU_IN;
`else
      model[dst] = C_MemToReg ? D_MDR_IN : D_ALU_IN;
`endif
    end
  end

  // Every-cycle comparison of all five read ports against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rd1",    D_ReadReg1RT, rst ? model[A_ReadReg1RT]    : 16'h0000);
      check("cyc_rd2",    D_ReadReg2RT, rst ? model[A_ReadReg2RT]    : 16'h0000);
      check("cyc_offset", D_Offset,     rst ? model[A_Offset]        : 16'h0000);
      check("cyc_regsw",  D_RegSW,      rst ? model[A_RegSWLW]       : 16'h0000);
      check("cyc_bt",     D_BT,         rst ? model[A_WriteRegRT_BT] : 16'h0000);
    end
  end

  task automatic set_all_addr(input logic [3:0] a);
    A_ReadReg1RT = a; A_ReadReg2RT = a; A_Offset = a; A_RegSWLW = a; A_WriteRegRT_BT = a;
  endtask

  task automatic check_all(input string name, input logic [15:0] exp);
    check({name, "_rd1"}, D_ReadReg1RT, exp);
    check({name, "_rd2"}, D_ReadReg2RT, exp);
    check({name, "_off"}, D_Offset, exp);
    check({name, "_sw"},  D_RegSW, exp);
    check({name, "_bt"},  D_BT, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] r0_exp;
    tests = 0; fails = 0; cmp_en = 1'b0;
    rst = 1'b1;
    D_MDR_IN = '0; D_ALU_IN = '0;
    set_all_addr(4'd0);
    C_RegDstWrite = 1'b0; C_RegWrite = 1'b0; C_MemToReg = 1'b0;
    #2 rst = 1'b0;
    step();
    cmp_en = 1'b1;

    // Reset: every port reads zero at every address.
    for (int a = 0; a < 16; a++) begin
      set_all_addr(4'(a));
      #1 check_all("reset", 16'h0000);
    end
    set_all_addr(4'd0);
    step();
    rst = 1'b1;

    // ALU write to R3.
    step();
    C_RegWrite = 1'b1; C_RegDstWrite = 1'b1; C_MemToReg = 1'b0;
    A_WriteRegRT_BT = 4'd3; D_ALU_IN = 16'hBEEF; A_ReadReg1RT = 4'd3;
    step();
    C_RegWrite = 1'b0;
    #1 check("alu_wr_rd1", D_ReadReg1RT, 16'hBEEF);
    check("alu_wr_bt", D_BT, 16'hBEEF);

    // MDR write to R7 via the SW/LW address.
    C_RegWrite = 1'b1; C_RegDstWrite = 1'b0; C_MemToReg = 1'b1;
    A_RegSWLW = 4'd7; D_MDR_IN = 16'h1234;
    step();
    C_RegWrite = 1'b0; A_Offset = 4'd7;
    #1 check("mdr_wr_sw", D_RegSW, 16'h1234);
    check("mdr_wr_off", D_Offset, 16'h1234);

    // Write disabled: R3 keeps its value.
    C_RegWrite = 1'b0; C_RegDstWrite = 1'b1; C_MemToReg = 1'b0;
    A_WriteRegRT_BT = 4'd3; D_ALU_IN = 16'hFFFF;
    step();
    A_ReadReg1RT = 4'd3;
    #1 check("wr_dis_r3", D_ReadReg1RT, 16'hBEEF);

    // Seed R5, then overwrite it and confirm there is no bypass.
    C_RegWrite = 1'b1; A_WriteRegRT_BT = 4'd5; D_ALU_IN = 16'h5A5A;
    step();
    D_ALU_IN = 16'h00AA; A_ReadReg2RT = 4'd5;
    #1 check("nobyp_before", D_ReadReg2RT, 16'h5A5A);
    step();
    C_RegWrite = 1'b0;
    #1 check("nobyp_after", D_ReadReg2RT, 16'h00AA);
    set_all_addr(4'd5);
    #1 check_all("multi_r5", 16'h00AA);

    // Top address, full-width pattern through the MDR path and RT destination.
    C_RegWrite = 1'b1; C_RegDstWrite = 1'b1; C_MemToReg = 1'b1;
    A_WriteRegRT_BT = 4'd15; D_MDR_IN = 16'h8001; D_ALU_IN = 16'h0000;
    step();
    C_RegWrite = 1'b0; A_ReadReg1RT = 4'd15;
    #1 check("r15_full", D_ReadReg1RT, 16'h8001);

    // R0 write.
`ifdef REG_ZERO_HARDWIRED_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'h5555;
`endif
    C_RegWrite = 1'b1; C_RegDstWrite = 1'b0; C_MemToReg = 1'b0;
    A_RegSWLW = 4'd0; D_ALU_IN = 16'h5555;
    step();
    C_RegWrite = 1'b0; A_ReadReg2RT = 4'd0;
    #1 check("r0_write", D_ReadReg2RT, r0_exp);

    // Async reset between edges, with a write pending that must be dropped.
    A_ReadReg1RT = 4'd3; A_ReadReg2RT = 4'd5; A_Offset = 4'd7; A_RegSWLW = 4'd15;
    A_WriteRegRT_BT = 4'd9; C_RegDstWrite = 1'b1; C_MemToReg = 1'b0; D_ALU_IN = 16'h7777;
    #1 check("pre_rst_r3", D_ReadReg1RT, 16'hBEEF);
    rst = 1'b0;
    #1 check("async_rst_rd1", D_ReadReg1RT, 16'h0000);
    check("async_rst_rd2", D_ReadReg2RT, 16'h0000);
    check("async_rst_off", D_Offset, 16'h0000);
    check("async_rst_sw",  D_RegSW, 16'h0000);
    C_RegWrite = 1'b1;
    step();
    #1 check("rst_prio_r9", D_BT, 16'h0000);
    rst = 1'b1;
    #1 check("rel_no_edge_r9", D_BT, 16'h0000);
    step();
    C_RegWrite = 1'b0;
    #1 check("first_wr_after_rst", D_BT, 16'h7777);
    check("r3_stays_clear", D_ReadReg1RT, 16'h0000);

    step();
    step();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
